// File: rtl/io_pkg.sv
// Shared definitions for the key event controller: debouncer state
// encoding, event word field positions and default parameter values.
package io_pkg;

    typedef enum logic [1:0] {
        STABLE_HI = 2'd0,
        CHK_LO    = 2'd1,
        STABLE_LO = 2'd2,
        CHK_HI    = 2'd3
    } deb_state_t;

    // Event word layout: [31:16] timestamp, [15:3] zero, [2:0] press mask
    localparam int TS_MSB           = 31;
    localparam int TS_LSB           = 16;
    localparam int TS_W             = TS_MSB - TS_LSB + 1;
    localparam int MASK_W           = 3;
    localparam int EVENT_W          = 32;

    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int FIFO_DEPTH_DEF   = 4;

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchronizer followed by a four-state
// debounce FSM. Produces the debounced active-low level and a one-cycle
// press pulse when a low level is accepted.
module key_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_vld;
    logic          r_armed;
    deb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    // Two-flop synchronizer, idles at the released level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Press pulses are only allowed once the key has been seen released
    // after reset; r_vld marks when r_sync2 holds a real sample rather
    // than its reset value, so a key held through reset never reports.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_vld <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Debounce FSM with registered level and press outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                STABLE_HI: begin
                    if (!r_sync2) begin
                        r_state <= CHK_LO;
                        r_cnt   <= ONE;
                    end
                end
                CHK_LO: begin
                    if (r_sync2) begin
                        r_state <= STABLE_HI;
                    end else if (r_cnt == LAST) begin
                        r_state <= STABLE_LO;
                        r_level <= 1'b0;
                        r_press <= r_armed;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                STABLE_LO: begin
                    if (r_sync2) begin
                        r_state <= CHK_HI;
                        r_cnt   <= ONE;
                    end
                end
                CHK_HI: begin
                    if (!r_sync2) begin
                        r_state <= STABLE_LO;
                    end else if (r_cnt == LAST) begin
                        r_state <= STABLE_HI;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_HI;
                    r_level <= 1'b1;
                end
            endcase
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: three debounced push buttons feed a timestamped
// event queue read by the CPU. Same-cycle presses merge into one event;
// pushes into a full queue are dropped and flagged in a sticky overflow.
module key_event_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:1]   key,
    input  logic         rd_en,
    input  logic         clr_ovf,
    output logic [31:0]  rd_data,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic [3:1]   key_level
);

    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [3:1]          w_press;
    logic [MASK_W-1:0]   w_mask;
    logic [EVENT_W-1:0]  w_event;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_empty;
    logic                w_full;

    logic [EVENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic [TS_W-1:0]     r_ts;
    logic                r_ovf;

    for (genvar g = 1; g <= 3; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .key_n (key[g]),
            .level (key_level[g]),
            .press (w_press[g])
        );
    end

    // key[1] lands in mask bit 0
    assign w_mask  = w_press;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = rd_en && !w_empty;
    assign w_push  = (w_mask != '0) && (!w_full || rd_en);
    assign w_drop  = (w_mask != '0) && w_full && !rd_en;

    // Event word assembly from the current timestamp and press mask
    always_comb begin
        w_event                 = '0;
        w_event[TS_MSB:TS_LSB]  = r_ts;
        w_event[MASK_W-1:0]     = w_mask;
    end

    // Free-running cycle timestamp
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Queue storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_event;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Show-ahead head entry, zero when nothing is queued
    always_comb begin
        rd_data = '0;
        if (!w_empty) begin
            rd_data = r_mem[r_rd_ptr];
        end
    end

    assign empty    = w_empty;
    assign full     = w_full;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed self-checking bench for key_event_ctrl (DEBOUNCE_CYCLES = 4,
// FIFO_DEPTH = 4). Expected event words are built from the cycle count
// since reset release and the known debounce latency.
module tb_key_event_ctrl;

    logic        clock;
    logic        reset;
    logic [3:1]  key;
    logic        rd_en;
    logic        clr_ovf;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [3:1]  key_level;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    key_event_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key      (key),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .key_level(key_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] evt(input logic [15:0] ts, input logic [2:0] m);
        return {ts, 13'b0, m};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Key low before edge c+1 -> push on edge c+7 capturing timestamp c+6
    task automatic press(input logic [3:1] k, output logic [15:0] ts);
        key = k;
        ts  = 16'(cyc + 6);
        repeat (8) tick();
        key = 3'b111;
        repeat (8) tick();
    endtask

    logic [15:0] t0, t1, t2, t3, t4;

    initial begin
        reset   = 1'b1;
        key     = 3'b111;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        @(posedge clock);
        #1;
        check("rst_empty",    32'(empty),     32'd1);
        check("rst_full",     32'(full),      32'd0);
        check("rst_overflow", 32'(overflow),  32'd0);
        check("rst_rd_data",  rd_data,        32'd0);
        check("rst_level",    32'(key_level), 32'h7);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
        repeat (4) tick();

        // Single press of key[1]: latency of level and event
        key = 3'b110;
        t0  = 16'(cyc + 6);
        repeat (5) tick();
        check("lat_level_early", 32'(key_level), 32'h7);
        tick();
        check("lat_level",       32'(key_level), 32'h6);
        check("lat_empty_early", 32'(empty),     32'd1);
        tick();
        check("lat_empty",       32'(empty),     32'd0);
        check("lat_rd_data",     rd_data,        evt(t0, 3'b001));
        repeat (13) tick();
        key = 3'b111;
        repeat (10) tick();
        check("release_level",   32'(key_level), 32'h7);
        check("release_no_evt",  rd_data,        evt(t0, 3'b001));
        pop();
        check("pop_empty",       32'(empty),     32'd1);
        check("pop_rd_data",     rd_data,        32'd0);

        // Pop while empty is ignored
        pop();
        check("pop_idle_empty",  32'(empty),     32'd1);
        check("pop_idle_full",   32'(full),      32'd0);

        // Short glitch on key[2]
        key = 3'b101;
        repeat (2) tick();
        key = 3'b111;
        repeat (10) tick();
        check("glitch_level",    32'(key_level), 32'h7);
        check("glitch_empty",    32'(empty),     32'd1);

        // Simultaneous key[1] + key[3]
        key = 3'b010;
        t0  = 16'(cyc + 6);
        repeat (7) tick();
        check("combo_level",     32'(key_level), 32'h2);
        check("combo_rd_data",   rd_data,        evt(t0, 3'b101));
        key = 3'b111;
        repeat (10) tick();
        pop();
        check("combo_single",    32'(empty),     32'd1);

        // Five presses into a four-deep queue
        press(3'b110, t0);
        press(3'b101, t1);
        press(3'b011, t2);
        press(3'b110, t3);
        check("fill4_full",      32'(full),      32'd1);
        check("fill4_ovf",       32'(overflow),  32'd0);
        press(3'b101, t4);
        check("ovf_full",        32'(full),      32'd1);
        check("ovf_set",         32'(overflow),  32'd1);
        check("ovf_head0",       rd_data,        evt(t0, 3'b001));
        pop();
        check("ovf_head1",       rd_data,        evt(t1, 3'b010));
        pop();
        check("ovf_head2",       rd_data,        evt(t2, 3'b100));
        pop();
        check("ovf_head3",       rd_data,        evt(t3, 3'b001));
        pop();
        check("ovf_drained",     32'(empty),     32'd1);
        check("ovf_sticky",      32'(overflow),  32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared",     32'(overflow),  32'd0);

        // Full queue, press lands on the same edge as a pop
        press(3'b110, t0);
        press(3'b110, t1);
        press(3'b110, t2);
        press(3'b110, t3);
        key = 3'b011;
        t4  = 16'(cyc + 6);
        repeat (6) tick();
        check("rw_head_before",  rd_data,        evt(t0, 3'b001));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rw_full",         32'(full),      32'd1);
        check("rw_ovf",          32'(overflow),  32'd0);
        check("rw_head_after",   rd_data,        evt(t1, 3'b001));
        key = 3'b111;
        repeat (8) tick();
        pop();
        check("rw_head2",        rd_data,        evt(t2, 3'b001));
        pop();
        check("rw_head3",        rd_data,        evt(t3, 3'b001));
        pop();
        check("rw_head4",        rd_data,        evt(t4, 3'b100));
        pop();
        check("rw_empty",        32'(empty),     32'd1);

        // Reset with queued events while key[2] is mid-debounce
        press(3'b110, t0);
        press(3'b011, t1);
        key = 3'b101;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_empty",   32'(empty),     32'd1);
        check("mid_rst_rd_data", rd_data,        32'd0);
        check("mid_rst_level",   32'(key_level), 32'h7);
        tick();
        reset = 1'b0;
        cyc   = 0;
        repeat (20) tick();
        check("held_level",      32'(key_level), 32'h5);
        check("held_no_evt",     32'(empty),     32'd1);
        key = 3'b111;
        repeat (8) tick();
        press(3'b011, t2);
        check("post_rst_evt",    rd_data,        evt(t2, 3'b100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
